// File: rtl/execute_redirect_pkg.sv
// -----------------------------------------------------------------------------
// execute_redirect_pkg
// Shared definitions for the execute-stage redirect/flush unit:
//   - state_t              : redirect controller state encoding
//   - FLUSH_CYCLES_DEFAULT : default number of younger stages to squash
//   - flush_cnt_width()    : width needed to hold a flush count of 0..n
// -----------------------------------------------------------------------------
package execute_redirect_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam int FLUSH_CYCLES_DEFAULT = 3;

    function automatic int flush_cnt_width(input int flush_cycles);
        return $clog2(flush_cycles + 1);
    endfunction

endpackage

// File: rtl/redirect_flush_counter.sv
// -----------------------------------------------------------------------------
// redirect_flush_counter
// Loadable down-counter that tracks the remaining flush cycles. It only
// counts while enabled and the pipeline is advancing; a stall freezes it.
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset (count cleared)
//   load_i       : load load_value_i (takes priority over counting)
//   load_value_i : value loaded into the counter
//   en_i         : counting enabled (controller is in its flush state)
//   stall_i      : pipeline stall, freezes the count
//   done_o       : last flush cycle is completing this cycle (count==1, no stall)
// -----------------------------------------------------------------------------
module redirect_flush_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             en_i,
    input  logic             stall_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (en_i && !stall_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1)) && !stall_i;

endmodule

// File: rtl/execute_redirect_unit.sv
// -----------------------------------------------------------------------------
// execute_redirect_unit
// Turns control-flow resolution from execute (taken branch / JALR) into a
// registered fetch redirect plus a multi-cycle flush of the stages younger
// than execute. A redirect resolved during a stall is held pending until the
// pipeline advances; events seen while busy are wrong-path and dropped.
// Ports:
//   clock          : clock, rising edge
//   reset          : asynchronous active-low reset
//   stall          : pipeline does not advance this cycle
//   ex_valid       : execute holds a valid, non-squashed instruction
//   branch         : conditional branch resolved taken
//   jalr           : instruction in execute is JALR
//   PC             : PC of instruction in execute
//   extend         : sign-extended branch offset
//   JALR_target    : JALR target (LSB already cleared)
//   redirect       : fetch must load redirect_PC
//   redirect_PC    : redirect target (holds last captured target)
//   flush          : squash all stages younger than execute
//   busy           : controller not idle
//   redirect_count : saturating count of issued redirects
//   report         : simulation reporting enable, no hardware effect
// -----------------------------------------------------------------------------
module execute_redirect_unit
    import execute_redirect_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    ex_valid,
    input  logic                    branch,
    input  logic                    jalr,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic [DATA_WIDTH-1:0]   extend,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    output logic                    redirect,
    output logic [ADDRESS_BITS-1:0] redirect_PC,
    output logic                    flush,
    output logic                    busy,
    output logic [31:0]             redirect_count,
    input  logic                    report
);

    localparam int               CNT_W    = flush_cnt_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    state_t                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] target_q, target_d;
    logic [31:0]             count_q, count_d;

    logic                    cf_event;
    logic [ADDRESS_BITS-1:0] target_calc;
    logic                    cnt_load;
    logic                    cnt_en;
    logic                    cnt_done;

    // Only the low ADDRESS_BITS of the offset matter: the target wraps
    // modulo the PC width. JALR takes priority over a simultaneous branch.
    assign cf_event    = ex_valid & (branch | jalr);
    assign target_calc = jalr ? JALR_target : (PC + extend[ADDRESS_BITS-1:0]);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        cnt_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cf_event) begin
                    target_d = target_calc;
                    state_d  = stall ? PENDING : REDIRECT;
                end
            end
            PENDING: begin
                if (!stall) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                // The redirect cycle is the first of the flush cycles.
                if (!stall) begin
                    count_d = sat_inc(count_q);
                    if (FLUSH_CYCLES == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = FLUSH;
                        cnt_load = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (cnt_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cnt_en = (state_q == FLUSH);

    redirect_flush_counter #(
        .CNT_W (CNT_W)
    ) u_flush_counter (
        .clk_i        (clock),
        .rst_ni       (reset),
        .load_i       (cnt_load),
        .load_value_i (CNT_LOAD),
        .en_i         (cnt_en),
        .stall_i      (stall),
        .done_o       (cnt_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end

    assign redirect       = (state_q == REDIRECT);
    assign flush          = (state_q == REDIRECT) || (state_q == FLUSH);
    assign busy           = (state_q != IDLE);
    assign redirect_PC    = target_q;
    assign redirect_count = count_q;

    // report and CORE only drive simulation-side reporting; the upper offset
    // bits are beyond the PC width and intentionally dropped.
    logic unused_ok;
    assign unused_ok = ^{report, extend, CORE};

endmodule
